// File: rtl/player_hp_ctrl_if.sv
// Player HP controller signal bundle.
// There is no valid/ready handshake on this bundle: start, tick and heal are
// single-cycle pulses that are acted on in the cycle they are high, damage is
// a level per enemy (only its rising edges matter), and every output is a
// registered level except hit_flash, which is a one-cycle pulse.
interface player_hp_ctrl_if;
  logic       start;
  logic       tick;
  logic [3:0] damage;
  logic       heal;
  logic [3:0] hp;
  logic       invuln;
  logic       hit_flash;
  logic       game_over;

  modport master (
    output start, tick, damage, heal,
    input  hp, invuln, hit_flash, game_over
  );

  modport slave (
    input  start, tick, damage, heal,
    output hp, invuln, hit_flash, game_over
  );
endinterface

// File: rtl/player_hp_ctrl.sv
// Player hit-point controller: tracks hp, applies enemy damage on rising
// edges, runs a post-hit invulnerability window and a game-over state.
// Optional feature macro: HP_HEAL_EN enables the heal request.
// dbg_state encoding: 0 IDLE, 1 ALIVE, 2 INVULN, 3 DEAD. dbg_cnt is the
// invulnerability counter.
module player_hp_ctrl #(
  parameter int MAX_HP       = 5,
  parameter int INVULN_TICKS = 32
) (
  input  logic             clk,
  input  logic             rst,
  player_hp_ctrl_if.slave  bus,
  output logic [1:0]       dbg_state,
  output logic [7:0]       dbg_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIVE  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } state_t;

`ifdef HP_HEAL_EN
  localparam bit HEAL_EN = 1'b1;
`else
  localparam bit HEAL_EN = 1'b0;
`endif

  localparam logic [3:0] MAX_HP_L = 4'(MAX_HP);
  localparam logic [7:0] TICKS_L  = 8'(INVULN_TICKS);

  state_t     state, state_n;
  logic [3:0] hp, hp_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] damage_prev;
  logic       flash_n;
  logic       invuln_q, flash_q, game_over_q;

  logic [3:0] new_hits;
  logic [2:0] n_hits;
  logic [4:0] hp_sub;
  logic [4:0] hp_inc;
  logic [3:0] hp_healed;

  // Next-state, next-hp and counter logic; restart always wins over damage.
  always_comb begin
    state_n  = state;
    hp_n     = hp;
    cnt_n    = cnt;
    flash_n  = 1'b0;
    new_hits = bus.damage & ~damage_prev;
    n_hits   = {2'b00, new_hits[0]} + {2'b00, new_hits[1]}
             + {2'b00, new_hits[2]} + {2'b00, new_hits[3]};
    // 5-bit arithmetic so a large hit goes negative instead of wrapping
    hp_sub    = {1'b0, hp} - {2'b00, n_hits};
    hp_inc    = {1'b0, hp} + 5'd1;
    hp_healed = (hp_inc > {1'b0, MAX_HP_L}) ? MAX_HP_L : hp_inc[3:0];

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = ALIVE;
          hp_n    = MAX_HP_L;
          cnt_n   = 8'd0;
        end
      end
      ALIVE: begin
        if (bus.start) begin
          state_n = ALIVE;
          hp_n    = MAX_HP_L;
          cnt_n   = 8'd0;
        end else if (n_hits != 3'd0) begin
          // simultaneous edges form one hit; a heal in this cycle is dropped
          flash_n = 1'b1;
          if (hp_sub[4] || hp_sub == 5'd0) begin
            state_n = DEAD;
            hp_n    = 4'd0;
            cnt_n   = 8'd0;
          end else begin
            state_n = INVULN;
            hp_n    = hp_sub[3:0];
            cnt_n   = TICKS_L;
          end
        end else if (HEAL_EN && bus.heal) begin
          hp_n = hp_healed;
        end
      end
      INVULN: begin
        if (bus.start) begin
          state_n = ALIVE;
          hp_n    = MAX_HP_L;
          cnt_n   = 8'd0;
        end else begin
          if (HEAL_EN && bus.heal) begin
            hp_n = hp_healed;
          end
          if (bus.tick) begin
            if (cnt == 8'd1) begin
              state_n = ALIVE;
              cnt_n   = 8'd0;
            end else begin
              cnt_n = cnt - 8'd1;
            end
          end
        end
      end
      DEAD: begin
        if (bus.start) begin
          state_n = ALIVE;
          hp_n    = MAX_HP_L;
          cnt_n   = 8'd0;
        end
      end
      default: begin
        state_n = IDLE;
        hp_n    = 4'd0;
        cnt_n   = 8'd0;
      end
    endcase
  end

  // State, hp, counter, edge history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hp          <= 4'd0;
      cnt         <= 8'd0;
      damage_prev <= 4'd0;
      invuln_q    <= 1'b0;
      flash_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state       <= state_n;
      hp          <= hp_n;
      cnt         <= cnt_n;
      damage_prev <= bus.damage;
      invuln_q    <= (state_n == INVULN);
      flash_q     <= flash_n;
      game_over_q <= (state_n == DEAD);
    end
  end

  assign bus.hp        = hp;
  assign bus.invuln    = invuln_q;
  assign bus.hit_flash = flash_q;
  assign bus.game_over = game_over_q;
  assign dbg_state     = state;
  assign dbg_cnt       = cnt;

endmodule

// File: tb/tb_player_hp_ctrl.sv
// Testbench for player_hp_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a game-rule reference model.
module tb_player_hp_ctrl;

  localparam int MAX_HP = 5;
  localparam int TICKS  = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  player_hp_ctrl_if bus ();
  logic [1:0] dbg_state;
  logic [7:0] dbg_cnt;

  player_hp_ctrl #(.MAX_HP(MAX_HP), .INVULN_TICKS(TICKS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: game started?, hp, remaining invulnerable ticks
  bit         m_started = 1'b0;
  int         m_hp      = 0;
  int         m_inv     = 0;
  logic [3:0] m_prev    = 4'd0;

  // expected bundle: hp[16:13] invuln[12] flash[11] game_over[10] cnt[9:2] state[1:0]
  logic [16:0] exp_q[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic t,
                            input logic [3:0] d, input logic h);
    int hits;
    bit flash;
    logic [1:0] st;
    hits  = $countones(d & ~m_prev);
    flash = 1'b0;
    if (r) begin
      m_started = 1'b0;
      m_hp      = 0;
      m_inv     = 0;
      m_prev    = 4'd0;
    end else begin
      m_prev = d;
      if (s) begin
        m_started = 1'b1;
        m_hp      = MAX_HP;
        m_inv     = 0;
      end else if (m_started && m_hp > 0) begin
        if (m_inv == 0 && hits > 0) begin
          flash = 1'b1;
          m_hp  = (m_hp > hits) ? m_hp - hits : 0;
          m_inv = (m_hp > 0) ? TICKS : 0;
        end else begin
          if (m_inv > 0 && t) m_inv--;
`ifdef HP_HEAL_EN
          if (h) m_hp = (m_hp + 1 > MAX_HP) ? MAX_HP : m_hp + 1;
`endif
        end
      end
    end
    if (!m_started)     st = 2'd0;
    else if (m_hp == 0) st = 2'd3;
    else if (m_inv > 0) st = 2'd2;
    else                st = 2'd1;
    exp_q.push_back({4'(m_hp), (m_inv > 0), flash, (m_started && m_hp == 0), 8'(m_inv), st});
  endtask

  // scoreboard: pop the model's expectation and compare every output
  task automatic compare_outputs();
    logic [16:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 8'd1, 8'd0);
      return;
    end
    e = exp_q.pop_front();
    check("hp",        {4'd0, bus.hp},        {4'd0, e[16:13]});
    check("invuln",    {7'd0, bus.invuln},    {7'd0, e[12]});
    check("hit_flash", {7'd0, bus.hit_flash}, {7'd0, e[11]});
    check("game_over", {7'd0, bus.game_over}, {7'd0, e[10]});
    check("counter",   dbg_cnt,               e[9:2]);
    check("state",     {6'd0, dbg_state},     {6'd0, e[1:0]});
  endtask

  // driver: apply one cycle of inputs, advance the model, check after the edge
  task automatic cycle(input logic s, input logic t, input logic [3:0] d,
                       input logic h, input logic r = 1'b0);
    rst        = r;
    bus.start  = s;
    bus.tick   = t;
    bus.damage = d;
    bus.heal   = h;
    @(posedge clk);
    model_step(r, s, t, d, h);
    #1;
    compare_outputs();
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.tick   = 1'b0;
    bus.damage = 4'd0;
    bus.heal   = 1'b0;

    // reset
    cycle(0, 0, 4'b0000, 0, 1);
    cycle(0, 0, 4'b1111, 0, 1);
    check("rst_hp", {4'd0, bus.hp}, 8'd0);
    check("rst_state", {6'd0, dbg_state}, 8'd0);
    // damage while idle is ignored
    cycle(0, 0, 4'b0000, 0);
    cycle(0, 0, 4'b0011, 0);
    check("idle_hp", {4'd0, bus.hp}, 8'd0);

    // start, then single hit held for three cycles
    cycle(1, 0, 4'b0000, 0);
    check("start_hp", {4'd0, bus.hp}, 8'd5);
    cycle(0, 0, 4'b0001, 0);
    check("hit1_hp", {4'd0, bus.hp}, 8'd4);
    check("hit1_flash", {7'd0, bus.hit_flash}, 8'd1);
    check("hit1_cnt", dbg_cnt, 8'd32);
    cycle(0, 0, 4'b0001, 0);
    check("hit1_flash_once", {7'd0, bus.hit_flash}, 8'd0);
    cycle(0, 0, 4'b0001, 0);

    // new edge while invulnerable is discarded; 32 ticks end the window
    cycle(0, 0, 4'b0101, 0);
    check("inv_hp", {4'd0, bus.hp}, 8'd4);
    for (int i = 0; i < TICKS; i++) cycle(0, 1, 4'b0101, 0);
    check("inv_end", {7'd0, bus.invuln}, 8'd0);
    cycle(0, 0, 4'b0111, 0);
    check("hit2_hp", {4'd0, bus.hp}, 8'd3);
    for (int i = 0; i < TICKS; i++) cycle(0, 1, 4'b0111, 0);

    // hit with tick in the same cycle: counter loads full length
    cycle(0, 1, 4'b1111, 0);
    check("tick_hit_cnt", dbg_cnt, 8'd32);
    check("tick_hit_hp", {4'd0, bus.hp}, 8'd2);
    for (int i = 0; i < TICKS; i++) cycle(0, 1, 4'b1111, 0);
    // level held across the window end is not a hit
    cycle(0, 0, 4'b1111, 0);
    check("held_hp", {4'd0, bus.hp}, 8'd2);

    // four simultaneous edges at hp=2 kill
    cycle(0, 0, 4'b0000, 0);
    cycle(0, 0, 4'b1111, 0);
    check("kill_hp", {4'd0, bus.hp}, 8'd0);
    check("kill_flash", {7'd0, bus.hit_flash}, 8'd1);
    check("kill_over", {7'd0, bus.game_over}, 8'd1);
    cycle(0, 0, 4'b0000, 1);
    cycle(0, 0, 4'b1111, 0);
    check("dead_hp", {4'd0, bus.hp}, 8'd0);
    cycle(1, 0, 4'b0000, 0);
    check("restart_hp", {4'd0, bus.hp}, 8'd5);
    check("restart_over", {7'd0, bus.game_over}, 8'd0);

    // heal together with a hit at hp=3: only damage applies
    cycle(0, 0, 4'b0011, 0);
    for (int i = 0; i < TICKS; i++) cycle(0, 1, 4'b0000, 0);
    cycle(0, 0, 4'b1000, 1);
    check("heal_hit_hp", {4'd0, bus.hp}, 8'd2);

    // heal steps (ignored when the feature is not built)
    cycle(1, 0, 4'b0000, 0);
    cycle(0, 0, 4'b0011, 0);
    check("pre_heal_hp", {4'd0, bus.hp}, 8'd3);
    cycle(0, 0, 4'b0011, 1);
`ifdef HP_HEAL_EN
    check("heal_3_4", {4'd0, bus.hp}, 8'd4);
`else
    check("heal_off", {4'd0, bus.hp}, 8'd3);
`endif
    cycle(0, 0, 4'b0011, 1);
    cycle(0, 0, 4'b0011, 1);
`ifdef HP_HEAL_EN
    check("heal_cap", {4'd0, bus.hp}, 8'd5);
`else
    check("heal_off2", {4'd0, bus.hp}, 8'd3);
`endif

    // reset during invulnerability at hp=2
    cycle(1, 0, 4'b0000, 0);
    cycle(0, 0, 4'b0111, 0);
    check("pre_rst_hp", {4'd0, bus.hp}, 8'd2);
    cycle(0, 0, 4'b0111, 0, 1);
    check("mid_rst_hp", {4'd0, bus.hp}, 8'd0);
    check("mid_rst_inv", {7'd0, bus.invuln}, 8'd0);
    check("mid_rst_state", {6'd0, dbg_state}, 8'd0);
    cycle(0, 0, 4'b0000, 0);
    cycle(0, 0, 4'b1111, 0);
    check("post_rst_ignore", {4'd0, bus.hp}, 8'd0);
    cycle(1, 0, 4'b1111, 0);

    // random stimulus
    begin
      logic [3:0] d;
      d = 4'b1111;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 3) == 0) d = 4'($urandom_range(0, 15));
        cycle($urandom_range(0, 79) == 0, $urandom_range(0, 2) == 0, d,
              $urandom_range(0, 7) == 0, $urandom_range(0, 399) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/player_hp_ctrl.md
PLAYER_HP_CTRL -- requirements
Module: player_hp_ctrl

Interface
REQ-001 Parameter MAX_HP, default 5; starting and maximum hit points, legal range 1..15.
REQ-002 Parameter INVULN_TICKS, default 32; length of the post-hit invulnerability window, counted in tick pulses, legal range 1..255.
REQ-003 Port clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: single-cycle pulse that begins or restarts a game.
REQ-006 Port tick, input, 1: single-cycle time-base pulse that advances the invulnerability timer.
REQ-007 Port damage, input, 4: level damage flags, one bit per enemy1 instance, from each instance's damage output.
REQ-008 Port heal, input, 1: single-cycle heal request.
REQ-009 Port hp, output, 4: current hit points.
REQ-010 Port invuln, output, 1: high while in state INVULN.
REQ-011 Port hit_flash, output, 1: single-cycle pulse on every accepted hit.
REQ-012 Port game_over, output, 1: high while in state DEAD.

Function
REQ-013 States are IDLE, ALIVE, INVULN and DEAD; all outputs are registered.
REQ-014 A per-bit rising-edge detector on damage uses a 4-bit previous-value register that updates every cycle in every state.
- new_hits = damage AND NOT damage_prev.
- n = popcount(new_hits), range 0..4.
REQ-015 IDLE: hp = 0 and damage edges are ignored.
- start goes to ALIVE at the next edge.
- On that edge, hp = MAX_HP.
REQ-016 ALIVE with n > 0: hp is set to max(hp - n, 0) at the same clock edge that first samples the rising damage bits, so latency is 1 cycle.
- hit_flash is high for exactly the following cycle.
REQ-017 ALIVE hit, result hp = 0: the next state is DEAD.
REQ-018 ALIVE hit, result hp > 0: the next state is INVULN.
- On the transition, the invulnerability counter loads INVULN_TICKS.
REQ-019 INVULN: new damage edges are discarded, with no hp change and no hit_flash.
- The counter decrements once per tick.
- When tick arrives with counter = 1, the next state is ALIVE.
REQ-020 A damage bit held high across the INVULN-to-ALIVE transition produces no hit, because only edges count.
REQ-021 DEAD: hp holds 0 and damage and heal are ignored.
- start goes to ALIVE with hp = MAX_HP.
REQ-022 start in ALIVE or INVULN restarts the game: hp = MAX_HP, state ALIVE, counter cleared.
- start has priority over damage in the same cycle.
REQ-023 The hp update uses a 5-bit intermediate, so subtraction never wraps.
- hp never exceeds MAX_HP.
REQ-024 Simultaneous damage edges from several enemies in one cycle form a single hit that removes n points.
- That hit produces one hit_flash and one invulnerability window.
REQ-025 tick and damage edge in the same ALIVE cycle: the hit is processed and tick has no effect on the freshly loaded counter.

Reset
REQ-026 rst, sampled at a rising clk edge, sets the following, overriding all other inputs:
- state = IDLE
- hp = 0
- counter = 0
- damage_prev = 0
- invuln = 0
- hit_flash = 0
- game_over = 0
REQ-027 rst asserted mid-game, including during INVULN or DEAD, returns the block to IDLE in one cycle.
- No output retains its pre-reset value after that edge.

Configuration
REQ-028 Macro HP_HEAL_EN, when defined, enables the heal function:
- heal in ALIVE or INVULN sets hp = min(hp + 1, MAX_HP).
- Heal does not change the state or the counter.
REQ-029 Under HP_HEAL_EN, heal in the same cycle as an accepted hit is dropped and only the damage is applied.
REQ-030 Without HP_HEAL_EN, the heal port exists but is ignored, and hp only decreases between starts.

Verification
REQ-031 rst, then start, then damage=0001 for 3 cycles -> hp 5 then 4 one cycle after the rise, one hit_flash, invuln=1, counter=32.
REQ-032 In INVULN, toggle damage[2] 0->1 -> hp stays 4; after 32 ticks invuln=0; a new rise of damage[1] -> hp=3.
REQ-033 ALIVE with hp=2, damage 0000->1111 in one cycle -> hp=0, one hit_flash, game_over=1; later start -> hp=5, game_over=0.
REQ-034 HP_HEAL_EN defined, hp=3 -> heal gives hp=4; heal at hp=5 gives hp=5; heal in the same cycle as a damage rise gives hp=2.
REQ-035 Assert rst during INVULN with hp=2 -> on the next cycle hp=0, invuln=0, state IDLE; damage edges are then ignored until start.
